dds_sweep_ctrl: RTL

- Frequency-sweep sequencer that generates the phase-increment (FCW) stream for the DDS compiler's AXI-Stream phase input.
- Steps a frequency control word from a start value to a stop value, holding each value for a programmable number of accepted samples.
- Supports single, sawtooth-repeat and triangle sweeps, and replaces a static fcw_input tie-off as the source of s_axis_phase_tdata/tvalid.

---
 rtl/dds_sweep_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS phase-increment AXI-Stream input.
// Steps an FCW from start to stop, holding each value for a set number of accepted beats.
module dds_sweep_ctrl #(
    parameter int unsigned FCW_W   = 32,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [FCW_W-1:0]   fcw_start,
    input  logic [FCW_W-1:0]   fcw_stop,
    input  logic [FCW_W-1:0]   fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic               m_axis_phase_tvalid,
    output logic [FCW_W-1:0]   m_axis_phase_tdata,
    input  logic               m_axis_phase_tready,
    output logic               busy,
    output logic               done,
    output logic [FCW_W-1:0]   fcw_current
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_SAW    = 2'd1;

    state_t             state;
    logic [1:0]         mode_r;
    logic [FCW_W-1:0]   start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r, cnt;
    logic               abort_pend;

    logic               beat, step_end, degen, at_top, at_bottom;
    logic [DWELL_W:0]   cnt_inc;
    logic [FCW_W:0]     up_sum, dn_diff;
    logic [FCW_W-1:0]   up_next, dn_next;

    // Clamped next values; one extra bit keeps carry/borrow from wrapping.
    always_comb begin
        beat      = m_axis_phase_tvalid & m_axis_phase_tready;
        cnt_inc   = {1'b0, cnt} + (DWELL_W+1)'(1);
        step_end  = beat && (cnt_inc == {1'b0, dwell_r});
        degen     = (stop_r <= start_r) || (step_r == '0);
        at_top    = m_axis_phase_tdata >= stop_r;
        at_bottom = m_axis_phase_tdata <= start_r;
        up_sum    = {1'b0, m_axis_phase_tdata} + {1'b0, step_r};
        dn_diff   = {1'b0, m_axis_phase_tdata} - {1'b0, step_r};
        up_next   = (up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[FCW_W-1:0];
        dn_next   = (dn_diff[FCW_W] || (dn_diff[FCW_W-1:0] <= start_r)) ?
                    start_r : dn_diff[FCW_W-1:0];
    end

    assign fcw_current = m_axis_phase_tdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            mode_r              <= '0;
            start_r             <= '0;
            stop_r              <= '0;
            step_r              <= '0;
            dwell_r             <= '0;
            cnt                 <= '0;
            abort_pend          <= 1'b0;
            m_axis_phase_tvalid <= 1'b0;
            m_axis_phase_tdata  <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (start) begin
                        mode_r              <= (mode == 2'd3) ? M_SINGLE : mode;
                        start_r             <= fcw_start;
                        stop_r              <= fcw_stop;
                        step_r              <= fcw_step;
                        dwell_r             <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        cnt                 <= '0;
                        state               <= UP;
                        busy                <= 1'b1;
                        m_axis_phase_tvalid <= 1'b1;
                        m_axis_phase_tdata  <= fcw_start;
                    end
                end
                default: begin
                    if (beat && (abort || abort_pend)) begin
                        // Abort takes effect on an accepted beat so tvalid never drops unaccepted.
                        state               <= IDLE;
                        busy                <= 1'b0;
                        m_axis_phase_tvalid <= 1'b0;
                        abort_pend          <= 1'b0;
                        cnt                 <= '0;
                    end else begin
                        if (abort) abort_pend <= 1'b1;
                        if (beat) cnt <= step_end ? '0 : cnt_inc[DWELL_W-1:0];
                        if (step_end) begin
                            if (state == UP) begin
                                if (degen || at_top) begin
                                    if (mode_r == M_SINGLE) begin
                                        state               <= IDLE;
                                        busy                <= 1'b0;
                                        m_axis_phase_tvalid <= 1'b0;
                                        done                <= 1'b1;
                                    end else if (degen || (mode_r == M_SAW)) begin
                                        done               <= 1'b1;
                                        m_axis_phase_tdata <= start_r;
                                    end else begin
                                        state              <= DOWN;
                                        m_axis_phase_tdata <= dn_next;
                                    end
                                end else begin
                                    m_axis_phase_tdata <= up_next;
                                end
                            end else begin
                                if (at_bottom) begin
                                    done               <= 1'b1;
                                    state              <= UP;
                                    m_axis_phase_tdata <= up_next;
                                end else begin
                                    m_axis_phase_tdata <= dn_next;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
